// File: rtl/noise_mem_pkg.sv
// -----------------------------------------------------------------------------
// noise_mem_pkg
// Shared types and constants for the noise-table memory writer.
//   state_t    : writer FSM states (IDLE, COLLECT, WRITE, DONE)
//   WORD_BYTES : bytes packed into one memory word
//   MEM_DATA_W : memory port-2 data width
//   addr_t     : port-2 address at the default width
//   csum_add   : running 16-bit byte checksum step
// -----------------------------------------------------------------------------
package noise_mem_pkg;

  localparam int WORD_BYTES     = 8;
  localparam int MEM_DATA_W     = 64;
  localparam int ADDR_W_DEFAULT = 14;
  localparam int BYTE_IDX_W     = 3;
  localparam int WCOUNT_W       = 9;
  localparam int CSUM_W         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

  // Checksum is the plain modulo-2^16 sum of zero-extended bytes.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + {{(CSUM_W-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/noise_table_writer_if.sv
// -----------------------------------------------------------------------------
// noise_table_writer_if
// Bundles the incoming byte stream and the outgoing memory port-2 write bus.
//   byte_in / byte_in_valid / byte_in_ready : valid/ready byte stream
//   mem_address / mem_write / mem_writedata / mem_byteenable : port-2 writes
// master : the writer (consumes bytes, drives the memory port)
// slave  : the byte source / memory side
// -----------------------------------------------------------------------------
interface noise_table_writer_if #(
  parameter int ADDR_W = 14
);
  import noise_mem_pkg::*;

  logic [7:0]            byte_in;
  logic                  byte_in_valid;
  logic                  byte_in_ready;

  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_write;
  logic [MEM_DATA_W-1:0] mem_writedata;
  logic [7:0]            mem_byteenable;

  modport master (
    input  byte_in,
    input  byte_in_valid,
    output byte_in_ready,
    output mem_address,
    output mem_write,
    output mem_writedata,
    output mem_byteenable
  );

  modport slave (
    output byte_in,
    output byte_in_valid,
    input  byte_in_ready,
    input  mem_address,
    input  mem_write,
    input  mem_writedata,
    input  mem_byteenable
  );

endinterface

// File: rtl/noise_table_writer_byte_packer_64.sv
// -----------------------------------------------------------------------------
// byte_packer_64
// Packs a byte stream little-endian into a 64-bit word: the n-th accepted byte
// of a word lands in bits [8n+7:8n].
//   clk, rstn : clock, synchronous active-low reset
//   i_clear   : discard partial word, restart at lane 0 (wins over i_wr)
//   i_wr      : accept i_byte into the current lane this cycle
//   i_byte    : data byte
//   o_word    : pack register (holds the complete word after lane 7 is written)
//   o_full    : the byte accepted this cycle completes the word
// -----------------------------------------------------------------------------
module byte_packer_64
  import noise_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_clear,
  input  logic                  i_wr,
  input  logic [7:0]            i_byte,
  output logic [MEM_DATA_W-1:0] o_word,
  output logic                  o_full
);

  logic [BYTE_IDX_W-1:0] r_idx;
  logic [MEM_DATA_W-1:0] r_pack;

  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (i_wr) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (r_idx == BYTE_IDX_W'(k)) r_pack[8*k +: 8] <= i_byte;
      end
      // Index wraps 7 -> 0 naturally, so back-to-back words need no clear.
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_word = r_pack;
  assign o_full = i_wr && (r_idx == BYTE_IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/noise_table_writer.sv
// -----------------------------------------------------------------------------
// noise_table_writer
// Writer side of the 64-bit noise-table memory port. Collects 8 bytes from the
// loader stream, packs them little-endian and writes the word to consecutive
// port-2 addresses (BASE_ADDR, +ADDR_STRIDE, ...). After NUM_WORDS words the
// block sits in DONE with done=1 so the control FSM can release load_mem.
//   clk, rstn   : clock, synchronous active-low reset
//   start       : 1-cycle pulse, begins a load from IDLE or DONE
//   abort       : 1-cycle pulse, cancels any load and returns to IDLE
//   wr          : byte stream in, memory port-2 write bus out
//   busy        : COLLECT or WRITE
//   done        : full table written, held until next start/abort
//   word_count  : words written in the current load
//   checksum    : 16-bit sum of accepted bytes in the current load
// -----------------------------------------------------------------------------
module noise_table_writer
  import noise_mem_pkg::*;
#(
  parameter int                ADDR_W      = 14,
  parameter int                NUM_WORDS   = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ADDR_STRIDE = 4
)(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  noise_table_writer_if.master     wr,
  output logic                     busy,
  output logic                     done,
  output logic [WCOUNT_W-1:0]      word_count,
  output logic [CSUM_W-1:0]        checksum
);

  state_t                r_state;
  logic                  r_ready;
  logic                  r_mem_write;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_W-1:0]     r_addr;
  logic [WCOUNT_W-1:0]   r_word_count;
  logic [CSUM_W-1:0]     r_checksum;

  logic                  w_xfer;
  logic                  w_start_ok;
  logic                  w_clear;
  logic                  w_full;
  logic [MEM_DATA_W-1:0] w_word;

  // r_ready is only ever set on entry to COLLECT, so it alone qualifies a transfer.
  assign w_xfer     = wr.byte_in_valid && r_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  // The pack register restarts on a new load, on abort (partial word dropped)
  // and after each WRITE; abort also suppresses any transfer in its cycle.
  assign w_clear = abort || w_start_ok || (r_state == WRITE);

  byte_packer_64 u_packer (
    .clk     (clk),
    .rstn    (rstn),
    .i_clear (w_clear),
    .i_wr    (w_xfer),
    .i_byte  (wr.byte_in),
    .o_word  (w_word),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_mem_write  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_addr       <= BASE_ADDR;
      r_word_count <= '0;
      r_checksum   <= '0;
    end else if (abort) begin
      // word_count and checksum deliberately keep their values for debug.
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= COLLECT;
            r_ready      <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_checksum   <= '0;
          end
        end

        COLLECT: begin
          if (w_xfer) begin
            r_checksum <= csum_add(r_checksum, wr.byte_in);
            if (w_full) begin
              r_state     <= WRITE;
              r_ready     <= 1'b0;
              r_mem_write <= 1'b1;
            end
          end
        end

        WRITE: begin
          r_mem_write  <= 1'b0;
          r_word_count <= r_word_count + 1'b1;
          // Address wraps modulo 2^ADDR_W without any error indication.
          r_addr       <= r_addr + ADDR_W'(ADDR_STRIDE);
          if (r_word_count == WCOUNT_W'(NUM_WORDS - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The pack register is complete and untouched for the whole WRITE cycle.
  assign wr.byte_in_ready  = r_ready;
  assign wr.mem_address    = r_addr;
  assign wr.mem_write      = r_mem_write;
  assign wr.mem_writedata  = w_word;
  assign wr.mem_byteenable = r_mem_write ? 8'hFF : 8'h00;

  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_word_count;
  assign checksum   = r_checksum;

endmodule

// File: doc/noise_table_writer.md
Name: noise_table_writer

Overview:
- Writer side of the 64-bit noise-table memory port.
- Accepts a byte stream (from the UART/NIOS loader path) and packs 8 bytes little-endian into one 64-bit word.
- Writes the packed words to consecutive on-chip-memory port-2 addresses, which the noise wrapper later reads back during its load phase.
- Signals completion so the control FSM can release load_mem.

Parameters:
- NUM_WORDS, 128, number of 64-bit words in one table load (1..256).
- BASE_ADDR, 14'h0000, port-2 address of the first word.
- ADDR_STRIDE, 4, address increment per written word (matches reader's addr2 step).
- ADDR_W, 14, memory port-2 address width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  1-cycle pulse; begins a load from IDLE or DONE
- abort  in  1  1-cycle pulse; cancels load, returns to IDLE
- byte_in  in  8  stream data byte
- byte_in_valid  in  1  byte_in holds a valid byte
- byte_in_ready  out  1  writer accepts byte this cycle (transfer = valid & ready)
- mem_address  out  ADDR_W  port-2 address
- mem_write  out  1  port-2 write strobe
- mem_writedata  out  64  packed word; byte k in bits [8k+7:8k]
- mem_byteenable  out  8  always 8'hFF while mem_write=1, else 8'h00
- busy  out  1  state is COLLECT or WRITE
- done  out  1  full table written; held until next start/abort
- word_count  out  9  words written in current load
- checksum  out  16  sum of all accepted bytes mod 2^16

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; all outputs 0; mem_address=BASE_ADDR; internal byte index, pack register and checksum cleared.
- States and transitions:
  - IDLE: ready=0. start -> COLLECT. On entry to COLLECT: byte_idx=0, word_count=0, checksum=0, mem_address=BASE_ADDR, done=0.
  - COLLECT: ready=1. Each transfer writes byte_in into lane byte_idx, increments byte_idx, adds zero-extended byte to checksum. Transfer with byte_idx==7 -> WRITE.
  - WRITE: exactly one cycle. mem_write=1, mem_writedata = full packed word, ready=0. At its end: word_count+1, mem_address += ADDR_STRIDE (mod 2^ADDR_W). If word_count reaches NUM_WORDS -> DONE, else -> COLLECT with byte_idx=0.
  - DONE: done=1, ready=0, mem_address keeps last-written address + stride. start -> COLLECT (re-arm, same entry actions).
- Latency: mem_write asserts in the cycle immediately after the 8th byte transfer. Sustained throughput is 8 bytes per 9 cycles.
- mem_address and mem_writedata are registered and stable for the whole WRITE cycle.
- start while busy: ignored.
- abort has priority over start and over all transitions. From any state it goes to IDLE next cycle: mem_write=0, done=0, partial word discarded. word_count and checksum hold their values for debug.
- abort and start in the same cycle: abort wins.
- byte_in_valid while ready=0: no transfer; the upstream source holds the byte.
- Address wrap: BASE_ADDR + NUM_WORDS*ADDR_STRIDE beyond 2^ADDR_W wraps silently. No error output.
- Reset mid-load: immediate return to reset values; no further mem_write.

Decomposition:
- Package noise_mem_pkg:
  - typedef enum state_t {IDLE, COLLECT, WRITE, DONE}
  - localparam WORD_BYTES=8, MEM_DATA_W=64
  - typedef addr_t logic [ADDR_W-1:0] with the default width
- Sub-module byte_packer_64: byte index counter, lane-write pack register, word_full flag, clear input. The FSM, address/count logic and checksum live in the top.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles, bytes offered -> all outputs 0, ready=0, mem_address=0, no writes.
- Single word (NUM_WORDS=1, BASE_ADDR=0x10), start, bytes 0x01..0x08 back-to-back -> one mem_write at 0x10 with data 64'h0807060504030201, byteenable 8'hFF, done=1 next cycle, checksum=0x0024, word_count=1.
- Full table (NUM_WORDS=128, STRIDE=4), 1024 bytes with random valid gaps -> 128 writes at addresses 0,4,...,0x1FC, data matches model, done=1, word_count=128, checksum matches model.
- Backpressure: valid held high during the WRITE cycle -> ready=0 that cycle, byte not consumed, accepted next cycle into lane 0 of the next word.
- Abort after 5 bytes of word 3 -> no write for word 3, state IDLE, done=0, ready=0. A new start reloads from BASE_ADDR with checksum restarted at 0.
- Wrap (BASE_ADDR=14'h3FFC, STRIDE=4, NUM_WORDS=2) -> writes at 0x3FFC then 0x0000. Also: start with abort in the same cycle -> remains IDLE.
